api_spi_xfer: RTL and testbench

- Parametrised successor to the fixed-width miner SPI shifter inside the API controller.
- Streams one work frame of WORK_LEN words from the TX FIFO side to one selected miner channel, and captures that channel's MISO into the RX FIFO side at the same time.
- Adds parametrised channel count and word width, a runtime SCK divider, runtime MSB/LSB-first order, and TX-underrun stall detection with abort.
- Sits between the TX/RX FIFOs and the board-level load/sck/mosi/miso pins.

---
 rtl/api_spi_pkg.sv | 25 ++
 rtl/api_spi_clkgen.sv | 55 +++++
 rtl/api_spi_xfer.sv | 205 ++++++++++++++++++++
 tb/tb_api_spi_xfer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/api_spi_pkg.sv
// api_spi_pkg: definitions shared by the miner SPI transfer engine.
//   state_e      - frame sequencer states
//   *_DEF        - default channel count, word width and frame length
//   ch_width()   - channel-select width derived from the channel count
package api_spi_pkg;

    localparam int API_NUM_DEF  = 32;
    localparam int DW_DEF       = 32;
    localparam int WORK_LEN_DEF = 23;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        FETCH,
        SHIFT,
        HOLD,
        ABORT
    } state_e;

    // A single channel still needs a 1-bit select so ports never collapse to zero width.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/api_spi_clkgen.sv
// api_spi_clkgen: SCK half-period generator.
//   clk_i, rst_i  - clock and asynchronous active-high reset
//   en_i          - run enable; while low the counter and sck are held at 0
//   h_i           - half period in clk cycles (must be >= 1)
//   rise_en_o     - strobe in the cycle whose closing edge raises sck
//   fall_en_o     - strobe in the cycle whose closing edge lowers sck
//   sck_o         - registered serial clock level, idle low
module api_spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] h_i,
    output logic             rise_en_o,
    output logic             fall_en_o,
    output logic             sck_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sck_q, sck_d;
    logic             phase_end;

    assign phase_end = en_i && (cnt_q == (h_i - DIV_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en_i) begin
            // Dropping the enable restarts the next word on a full low phase.
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (phase_end) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign rise_en_o = phase_end && !sck_q;
    assign fall_en_o = phase_end && sck_q;
    assign sck_o     = sck_q;

endmodule

// File: rtl/api_spi_xfer.sv
// api_spi_xfer: streams one work frame of WORK_LEN words from the TX FIFO to
// one miner channel over SPI mode 0 while capturing that channel's MISO.
//   CLK_I, RST_I         - clock, asynchronous active-high reset
//   start, ch_sel,
//   reg_sck, lsb_first   - frame request and its settings (latched on start)
//   tx_valid, tx_data,
//   tx_ready             - TX FIFO side; tx_ready is a one-cycle pop strobe
//   rx_valid, rx_data,
//   rx_ch                - RX FIFO side; rx_valid is a one-cycle push strobe
//   busy, done, err      - status; done/err are one-cycle completion pulses
//   load, sck, mosi, miso- board pins, load one-hot on the active channel
module api_spi_xfer
    import api_spi_pkg::*;
#(
    parameter int API_NUM   = API_NUM_DEF,
    parameter int DW        = DW_DEF,
    parameter int WORK_LEN  = WORK_LEN_DEF,
    parameter int DIV_W     = 8,
    parameter int STALL_MAX = 65535,
    parameter int CH_W      = ch_width(API_NUM)
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic               start,
    input  logic [CH_W-1:0]    ch_sel,
    input  logic [DIV_W-1:0]   reg_sck,
    input  logic               lsb_first,
    input  logic               tx_valid,
    input  logic [DW-1:0]      tx_data,
    output logic               tx_ready,
    output logic               rx_valid,
    output logic [DW-1:0]      rx_data,
    output logic [CH_W-1:0]    rx_ch,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [API_NUM-1:0] load,
    output logic               sck,
    output logic               mosi,
    input  logic [API_NUM-1:0] miso
);

    localparam int WC_W = $clog2(WORK_LEN + 1);
    localparam int ST_W = $clog2(STALL_MAX + 1);
    localparam int BC_W = (DW > 1) ? $clog2(DW) : 1;

    state_e             state_q;
    logic [CH_W-1:0]    ch_q;
    logic [DIV_W-1:0]   h_q;
    logic [DIV_W-1:0]   cnt_q;
    logic               lsb_q;
    logic [WC_W-1:0]    word_cnt_q;
    logic [ST_W-1:0]    stall_q;
    logic [BC_W-1:0]    bit_cnt_q;
    logic [DW-1:0]      tx_sh_q;
    logic [DW-1:0]      rx_sh_q;
    logic [DW-1:0]      rx_data_q;
    logic [CH_W-1:0]    rx_ch_q;
    logic [API_NUM-1:0] load_q;
    logic               mosi_q;
    logic               tx_ready_q;
    logic               rx_valid_q;
    logic               done_q;
    logic               err_q;

    logic rise_en;
    logic fall_en;
    logic sck_w;
    logic miso_bit;

    assign miso_bit = miso[ch_q];

    api_spi_clkgen #(
        .DIV_W(DIV_W)
    ) u_clkgen (
        .clk_i    (CLK_I),
        .rst_i    (RST_I),
        .en_i     (state_q == SHIFT),
        .h_i      (h_q),
        .rise_en_o(rise_en),
        .fall_en_o(fall_en),
        .sck_o    (sck_w)
    );

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            h_q        <= DIV_W'(1);
            cnt_q      <= '0;
            lsb_q      <= 1'b0;
            word_cnt_q <= '0;
            stall_q    <= '0;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_ch_q    <= '0;
            load_q     <= '0;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ch_q       <= ch_sel;
                        h_q        <= (reg_sck == '0) ? DIV_W'(1) : reg_sck;
                        lsb_q      <= lsb_first;
                        word_cnt_q <= '0;
                        stall_q    <= '0;
                        cnt_q      <= '0;
                        load_q     <= API_NUM'(1) << ch_sel;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == (h_q - DIV_W'(1))) begin
                        cnt_q   <= '0;
                        state_q <= FETCH;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                FETCH: begin
                    if (tx_valid) begin
                        tx_ready_q <= 1'b1;
                        tx_sh_q    <= tx_data;
                        mosi_q     <= lsb_q ? tx_data[0] : tx_data[DW-1];
                        bit_cnt_q  <= '0;
                        state_q    <= SHIFT;
                    end else if (stall_q == ST_W'(STALL_MAX - 1)) begin
                        // The stall budget spans the whole frame, not each word.
                        stall_q <= stall_q + ST_W'(1);
                        load_q  <= '0;
                        mosi_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ABORT;
                    end else begin
                        stall_q <= stall_q + ST_W'(1);
                    end
                end
                SHIFT: begin
                    if (rise_en) begin
                        rx_sh_q <= lsb_q ? {miso_bit, rx_sh_q[DW-1:1]}
                                         : {rx_sh_q[DW-2:0], miso_bit};
                    end
                    if (fall_en) begin
                        if (bit_cnt_q == BC_W'(DW - 1)) begin
                            // Last rise was H cycles ago, so rx_sh_q is complete.
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sh_q;
                            rx_ch_q    <= ch_q;
                            word_cnt_q <= word_cnt_q + WC_W'(1);
                            if (word_cnt_q == WC_W'(WORK_LEN - 1)) begin
                                load_q  <= '0;
                                mosi_q  <= 1'b0;
                                cnt_q   <= '0;
                                state_q <= HOLD;
                            end else begin
                                state_q <= FETCH;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                            tx_sh_q   <= lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                            mosi_q    <= lsb_q ? tx_sh_q[1] : tx_sh_q[DW-2];
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == (h_q - DIV_W'(1))) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                ABORT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_ch    = rx_ch_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign load     = load_q;
    assign sck      = sck_w;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_api_spi_xfer.sv
// tb_api_spi_xfer: randomized frame-level bench for api_spi_xfer.
// Each frame is predicted from the frame rules: total length from H, DW,
// WORK_LEN and stall cycles, the serial bit order on mosi, loopback words on
// rx_data, one-hot load, and sck phase widths.
module tb_api_spi_xfer;

    localparam int API_NUM   = 4;
    localparam int DW        = 8;
    localparam int WORK_LEN  = 2;
    localparam int DIV_W     = 8;
    localparam int STALL_MAX = 20;
    localparam int CH_W      = 2;

    logic               clk;
    logic               rst;
    logic               start;
    logic [CH_W-1:0]    ch_sel;
    logic [DIV_W-1:0]   reg_sck;
    logic               lsb_first;
    logic               tx_valid;
    logic [DW-1:0]      tx_data;
    logic               tx_ready;
    logic               rx_valid;
    logic [DW-1:0]      rx_data;
    logic [CH_W-1:0]    rx_ch;
    logic               busy;
    logic               done;
    logic               err;
    logic [API_NUM-1:0] load;
    logic               sck;
    logic               mosi;
    logic [API_NUM-1:0] miso;
    logic [API_NUM-1:0] miso_noise;
    int                 cur_ch;

    int errors = 0;
    int checks = 0;

    api_spi_xfer #(
        .API_NUM  (API_NUM),
        .DW       (DW),
        .WORK_LEN (WORK_LEN),
        .DIV_W    (DIV_W),
        .STALL_MAX(STALL_MAX)
    ) dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .start    (start),
        .ch_sel   (ch_sel),
        .reg_sck  (reg_sck),
        .lsb_first(lsb_first),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ch    (rx_ch),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .load     (load),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selected channel loops mosi back; every other channel carries noise.
    always_comb begin
        miso         = miso_noise;
        miso[cur_ch] = mosi;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
    endfunction

    function automatic logic [API_NUM-1:0] one_hot(input int ch);
        logic [API_NUM-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    // stall: clk cycles tx_valid stays low once word 0 is pushed to RX
    // (>= STALL_MAX means never, so the frame must abort).
    task automatic run_frame(input int ch, input int rsck, input bit lsb,
                             input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input int stall, input bit mid_start);
        logic [DW-1:0] words [WORK_LEN];
        logic [DW-1:0] sent;
        int  h, ppw, exp_len, nw_exp;
        int  cyc, popped, rx_n, bit_idx, hi_len, lo_len, stall_left;
        bit  exp_abort, prev_sck, fin;

        words[0]  = w0;
        words[1]  = w1;
        h         = (rsck == 0) ? 1 : rsck;
        ppw       = 1 + 2 * h * DW;
        exp_abort = (stall >= STALL_MAX);
        nw_exp    = exp_abort ? 1 : WORK_LEN;
        exp_len   = exp_abort ? (h + ppw + STALL_MAX + 1)
                              : (2 * h + WORK_LEN * ppw + 1 + stall);

        @(negedge clk);
        cur_ch    = ch;
        ch_sel    = CH_W'(ch);
        reg_sck   = DIV_W'(rsck);
        lsb_first = lsb;
        start     = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = words[0];
        popped = 0; rx_n = 0; bit_idx = 0; hi_len = 0; lo_len = 0;
        stall_left = 0; cyc = 0; sent = '0; prev_sck = 1'b0; fin = 1'b0;

        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            miso_noise = API_NUM'($urandom);
            start = mid_start && (cyc == 5);
            if (start) begin
                ch_sel  = CH_W'((ch + 1) % API_NUM);
                reg_sck = DIV_W'(h + 2);
            end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0 && popped < WORK_LEN) tx_valid = 1'b1;
            end
            if (tx_ready) begin
                popped++;
                if (popped < WORK_LEN) begin
                    tx_data  = words[popped];
                    tx_valid = (stall == 0);
                end else begin
                    tx_valid = 1'b0;
                end
            end
            if (sck && !prev_sck) begin
                check("load", load, one_hot(ch));
                if (bit_idx != 0) check("sck_lo", lo_len, h);
                sent = {sent[DW-2:0], mosi};
                bit_idx++;
                hi_len = 1;
            end else if (sck) begin
                hi_len++;
            end
            if (!sck && prev_sck) begin
                check("sck_hi", hi_len, h);
                lo_len = 1;
            end else if (!sck) begin
                lo_len++;
            end
            prev_sck = sck;
            if (rx_valid) begin
                check("rx_data", rx_data, words[rx_n]);
                check("rx_ch", rx_ch, ch);
                check("mosi", sent, lsb ? bit_rev(words[rx_n]) : words[rx_n]);
                check("bits", bit_idx, DW);
                bit_idx = 0;
                sent    = '0;
                rx_n++;
                if (rx_n == 1 && stall > 0) stall_left = stall;
            end
            check("busy", busy, !done);
            if (done || err) begin
                fin = 1'b1;
                check("end_err", err, exp_abort);
                check("end_cycle", cyc, exp_len);
                check("end_load", load, 0);
                check("end_sck", sck, 0);
                check("rx_count", rx_n, nw_exp);
                check("tx_pops", popped, nw_exp);
            end
        end
        if (!fin) check("timeout", 0, 1);
        start    = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle", {done, err, tx_ready, rx_valid, busy, sck, load}, 0);
        end
        $display("frame ch=%0d reg_sck=%0d lsb=%0d stall=%0d words=%0h,%0h cycles=%0d",
                 ch, rsck, lsb, stall, w0, w1, cyc);
    endtask

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; ch_sel = '0; reg_sck = '0; lsb_first = 1'b0;
        tx_valid = 1'b0; tx_data = '0; miso_noise = '0; cur_ch = 0;
        #1;
        check("reset_async", {tx_ready, rx_valid, rx_data, rx_ch, busy, done, err, load, sck, mosi}, 0);
        repeat (3) @(negedge clk);
        check("reset_held", {tx_ready, rx_valid, rx_data, rx_ch, busy, done, err, load, sck, mosi}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(3, 1, 1'b0, 8'hA5, 8'h3C, 0, 1'b0);
        run_frame(3, 1, 1'b1, 8'hA5, 8'h3C, 0, 1'b0);
        run_frame(3, 0, 1'b0, 8'hA5, 8'h3C, 0, 1'b0);
        run_frame(3, 4, 1'b0, 8'hA5, 8'h3C, 0, 1'b0);
        run_frame(3, 1, 1'b0, 8'hA5, 8'h3C, 10, 1'b0);
        run_frame(3, 1, 1'b0, 8'hA5, 8'h3C, 1000, 1'b0);
        run_frame(1, 2, 1'b1, 8'h5A, 8'hC3, 0, 1'b1);

        for (int f = 0; f < 16; f++) begin
            int st;
            st = ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(0, 5);
            run_frame($urandom_range(0, API_NUM - 1), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom),
                      st, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a bit: pins and status must drop at once.
        @(negedge clk);
        cur_ch = 2; ch_sel = 2'd2; reg_sck = 8'd2; lsb_first = 1'b0;
        tx_valid = 1'b1; tx_data = 8'h96; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!sck && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rst_reach_shift", sck, 1);
        rst = 1'b1;
        #1;
        check("rst_mid", {load, sck, busy, rx_valid, done, err}, 0);
        @(negedge clk);
        check("rst_mid_held", {load, sck, busy, rx_valid, done, err}, 0);
        rst = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        run_frame(0, 1, 1'b0, 8'h81, 8'h7E, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
